// File: rtl/fft32_bitrev_reorder_if.sv
// Sample bus between the FFT32 core output and the reorder stage, plus the natural-order result stream.
interface fft32_bitrev_reorder_if #(
   parameter int NB    = 16,
   parameter int LOG2N = 5
);
   logic             START_I;
   logic [NB-1:0]    DR_I;
   logic [NB-1:0]    DI_I;
   logic [NB-1:0]    DR_O;
   logic [NB-1:0]    DI_O;
   logic             VLD_O;
   logic             FRM_O;
   logic [LOG2N-1:0] IDX_O;
   logic             ERR_O;

   modport master (
      output START_I, DR_I, DI_I,
      input  DR_O, DI_O, VLD_O, FRM_O, IDX_O, ERR_O
   );

   modport slave (
      input  START_I, DR_I, DI_I,
      output DR_O, DI_O, VLD_O, FRM_O, IDX_O, ERR_O
   );
endinterface

// File: rtl/fft32_bitrev_reorder.sv
// Ping-pong frame buffer turning FFT32 bit-reversed output into natural order; 32-cycle latency, no backpressure.
// BITREV_REORDER_EN selects bit-reversed write addressing; undefined gives a plain 32-cycle frame delay.
module fft32_bitrev_reorder #(
   parameter int NB    = 16,
   parameter int LOG2N = 5
) (
   input  logic                  CLK,
   input  logic                  RST,
   fft32_bitrev_reorder_if.slave bus
);
   localparam int N = 1 << LOG2N;
   localparam logic [LOG2N-1:0] LAST = '1;

   typedef enum logic {W_IDLE, W_RUN} wstate_t;
   typedef enum logic {R_IDLE, R_RUN} rstate_t;

   wstate_t          ws_q, ws_d;
   rstate_t          rs_q, rs_d;
   logic [LOG2N-1:0] wcnt_q, wcnt_d;
   logic [LOG2N-1:0] rcnt_q, rcnt_d;
   logic             wbank_q, wbank_d;
   logic             rbank_q, rbank_d;
   logic [1:0]       full_q, full_d;
   logic [1:0]       full_set, full_clr;
   logic             abort_q, abort_d;
   logic [NB-1:0]    dr_q, dr_d;
   logic [NB-1:0]    di_q, di_d;
   logic [LOG2N-1:0] idx_q, idx_d;
   logic             vld_q, vld_d;
   logic             frm_q, frm_d;
   logic             err_q;

   logic [2*NB-1:0]  mem_q [2][N];
   logic             we;
   logic [LOG2N-1:0] wptr;
   logic [LOG2N-1:0] waddr;
   logic [2*NB-1:0]  rdat;

`ifdef BITREV_REORDER_EN
   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
      logic [LOG2N-1:0] r;
      for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
      return r;
   endfunction
   assign waddr = bitrev(wptr);
`else
   assign waddr = wptr;
`endif

   // A START_I seen while a frame is open (including on its last sample) restarts that frame in place.
   always_comb begin
      ws_d     = ws_q;
      wcnt_d   = wcnt_q;
      wbank_d  = wbank_q;
      we       = 1'b0;
      wptr     = wcnt_q;
      abort_d  = 1'b0;
      full_set = '0;
      case (ws_q)
         W_IDLE: begin
            if (bus.START_I) begin
               we     = 1'b1;
               wptr   = '0;
               wcnt_d = LOG2N'(1);
               ws_d   = W_RUN;
            end
         end
         W_RUN: begin
            we = 1'b1;
            if (bus.START_I) begin
               wptr    = '0;
               wcnt_d  = LOG2N'(1);
               abort_d = 1'b1;
            end else begin
               wcnt_d = wcnt_q + LOG2N'(1);
               if (wcnt_q == LAST) begin
                  full_set[wbank_q] = 1'b1;
                  wbank_d           = ~wbank_q;
                  ws_d              = W_IDLE;
               end
            end
         end
         default: ws_d = W_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (we) mem_q[wbank_q][waddr] <= {bus.DR_I, bus.DI_I};
   end

   // Bin 0 is emitted on the same edge that first sees the bank full, so idle->run costs no cycle.
   always_comb begin
      rs_d     = rs_q;
      rcnt_d   = rcnt_q;
      rbank_d  = rbank_q;
      full_clr = '0;
      dr_d     = dr_q;
      di_d     = di_q;
      idx_d    = idx_q;
      vld_d    = 1'b0;
      frm_d    = 1'b0;
      rdat     = mem_q[rbank_q][rcnt_q];
      if (rs_q == R_RUN || full_q[rbank_q]) begin
         dr_d   = rdat[2*NB-1:NB];
         di_d   = rdat[NB-1:0];
         idx_d  = rcnt_q;
         vld_d  = 1'b1;
         frm_d  = (rcnt_q == '0);
         rcnt_d = rcnt_q + LOG2N'(1);
         rs_d   = R_RUN;
         if (rcnt_q == LAST) begin
            full_clr[rbank_q] = 1'b1;
            rbank_d           = ~rbank_q;
            rs_d              = full_q[~rbank_q] ? R_RUN : R_IDLE;
         end
      end
   end

   assign full_d = (full_q & ~full_clr) | full_set;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ws_q    <= W_IDLE;
         rs_q    <= R_IDLE;
         wcnt_q  <= '0;
         rcnt_q  <= '0;
         wbank_q <= 1'b0;
         rbank_q <= 1'b0;
         full_q  <= 2'b00;
         abort_q <= 1'b0;
         err_q   <= 1'b0;
         dr_q    <= '0;
         di_q    <= '0;
         idx_q   <= '0;
         vld_q   <= 1'b0;
         frm_q   <= 1'b0;
      end else begin
         ws_q    <= ws_d;
         rs_q    <= rs_d;
         wcnt_q  <= wcnt_d;
         rcnt_q  <= rcnt_d;
         wbank_q <= wbank_d;
         rbank_q <= rbank_d;
         full_q  <= full_d;
         abort_q <= abort_d;
         err_q   <= abort_q;
         dr_q    <= dr_d;
         di_q    <= di_d;
         idx_q   <= idx_d;
         vld_q   <= vld_d;
         frm_q   <= frm_d;
      end
   end

   assign bus.DR_O  = dr_q;
   assign bus.DI_O  = di_q;
   assign bus.IDX_O = idx_q;
   assign bus.VLD_O = vld_q;
   assign bus.FRM_O = frm_q;
   assign bus.ERR_O = err_q;
endmodule

// File: doc/fft32_bitrev_reorder.md
# fft32_bitrev_reorder

Output reorder stage placed directly downstream of the serial FFT32 core. FFT32 emits each 32-point frame one complex sample per cycle in bit-reversed index order. This block buffers each frame in a two-bank ping-pong register array and replays it in natural order (bin 0..31), at full throughput with a fixed latency. The natural-order stream feeds the spectral post-processing stages.

## Interface
- NB, 16: width of one SFP word; matches FFT32 DR/DI/OR/OI.
- LOG2N, 5: log2 of frame length; fixed to 5 (32 points) for this block.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- START_I  in  1  one-cycle pulse sampled with the first sample (bit-reversed index 0) of a frame.
- DR_I  in  NB  real part of incoming sample (FFT32 OR).
- DI_I  in  NB  imaginary part of incoming sample (FFT32 OI).
- DR_O  out  NB  real part, natural order.
- DI_O  out  NB  imaginary part, natural order.
- VLD_O  out  1  DR_O/DI_O hold a valid sample.
- FRM_O  out  1  high with bin 0 of each output frame.
- IDX_O  out  LOG2N  natural bin index of the current output sample.
- ERR_O  out  1  one-cycle pulse: frame restarted before completion.

## Operation
- Storage: 2 banks x 32 entries x 2·NB bits (register array, asynchronous read).
- Write FSM, states W_IDLE, W_RUN; 5-bit counter wcnt, 1-bit wbank.
  - W_IDLE + START_I: write sample to bank wbank at address bitrev(0)=0, wcnt←1, go W_RUN.
  - W_RUN: each cycle write sample k=wcnt at address bitrev(k) (bits [4:0] reversed); wcnt++.
  - At k=31: set full[wbank], toggle wbank, go W_IDLE. wcnt wraps 31→0.
  - START_I in W_RUN with wcnt≠0: abort frame, pulse ERR_O, restart at wcnt←1 in the same bank (sample written at address 0); partial frame discarded, full flag untouched.
  - START_I in the same cycle as the k=31 write: k=31 sample completes the frame (not an error), bank toggles, and the new frame begins in the other bank? No: START_I is only legal after k=31; a START_I coincident with k=31 is treated as abort (ERR_O pulse).
- Read FSM, states R_IDLE, R_RUN; 5-bit counter rcnt, 1-bit rbank.
  - R_IDLE + full[rbank]: go R_RUN, rcnt←0.
  - R_RUN: register entry rcnt of rbank onto DR_O/DI_O, IDX_O←rcnt, VLD_O←1, FRM_O←(rcnt==0); rcnt++.
  - After rcnt=31: clear full[rbank], toggle rbank; if full of the other bank is set, continue R_RUN at rcnt=0 without a gap, else R_IDLE.
- Overflow is impossible: read rate equals write rate and a bank is rewritten no earlier than 32 cycles after its read begins.
- Data is not modified; no arithmetic on samples.

## Timing
- Reset: DR_O=0, DI_O=0, VLD_O=0, FRM_O=0, IDX_O=0, ERR_O=0; wcnt=rcnt=0, wbank=rbank=0, full=2'b00, both FSMs idle. Array contents not reset.
- Reset mid-frame discards all buffered and partial frames.
- Let E0 be the edge sampling START_I. Sample k captured at edge E0+k; full set at E0+31.
- Bin n registered onto outputs at edge E0+32+n; latency 32 cycles; VLD_O high 32 consecutive cycles per frame.
- Back-to-back frames (START_I at E0+32) produce a gapless output with FRM_O every 32 cycles.
- Gaps between input frames produce VLD_O low gaps of equal length.
- ERR_O asserted at edge following the offending START_I edge, for one cycle.

## Configuration
- BITREV_REORDER_EN defined: write address bitrev(wcnt) as above.
- Not defined: write address = wcnt (pure 32-cycle frame delay, output order equals arrival order); all timing, flags and ERR_O behaviour unchanged.

## Test plan
- Single frame: START_I at E0, DR_I=k, DI_I=31-k for sample k -> at E0+32+n: DR_O=bitrev(n), DI_O=31-bitrev(n), IDX_O=n, FRM_O only at n=0.
- Natural recovery: DR_I=bitrev(k) -> DR_O=n for n=0..31; with BITREV_REORDER_EN undefined, DR_O=bitrev(n).
- Back-to-back 3 frames (START_I at E0, E0+32, E0+64, DR_I=frame·32+bitrev(k)) -> VLD_O high 96 cycles from E0+32, DR_O=0..95 contiguous, FRM_O at E0+32/64/96.
- Abort: START_I at E0, again at E0+10 -> ERR_O pulse at E0+11; first output at E0+42, no output from the aborted frame.
- Idle gap: frames at E0 and E0+50 -> VLD_O low E0+64..E0+81, second frame starts E0+82.
- Async reset asserted at E0+40 mid-read -> outputs zero immediately; no VLD_O until a new START_I plus 32 cycles.
